// File: rtl/core_pkg.sv
// Shared types and constants for the five-stage core's memory stage.
package core_pkg;

  localparam int LANES      = 4;
  localparam int WORD_BYTES = 4;
  localparam int BEAT_W     = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

endpackage

// File: rtl/dmem_beat_ctrl.sv
// Sequences scalar/vector accesses as 32-bit beats on the data-memory bus
// and assembles read beats into a lane buffer.
module dmem_beat_ctrl
  import core_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic                   vector_op,
  input  logic [29:0]            addr_word,
  input  logic [32*LANES-1:0]    write_data,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [31:0]            dmem_addr,
  output logic [31:0]            dmem_wdata,
  input  logic                   dmem_ack,
  input  logic [31:0]            dmem_rdata,
  output logic                   mem_stall,
  output logic [LANES-1:0][31:0] read_buf
);

  mem_state_t              state, state_next;
  logic [BEAT_W-1:0]       beat;
  logic [BEAT_W-1:0]       last_beat;
  logic [LANES-1:0][31:0]  write_lanes;
  logic [31:0]             beat_addr;
  logic                    acc;
  logic                    busy;

  assign acc         = mem_read | mem_write;
  assign busy        = (state == BUSY);
  assign last_beat   = vector_op ? BEAT_W'(LANES - 1) : '0;
  assign write_lanes = write_data;
  // Beat addresses wrap naturally in 32 bits past 0xFFFFFFFC.
  assign beat_addr   = {addr_word, 2'b00} + (32'(beat) * 32'(WORD_BYTES));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (acc) state_next = BUSY;
      BUSY:    if (dmem_ack && (beat == last_beat)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat <= '0;
    end else if (state == IDLE) begin
      beat <= '0;
    end else if (busy && dmem_ack && (beat != last_beat)) begin
      beat <= beat + 1'b1;
    end
  end

  // NOTE: the read buffer is a handful of flops, not a RAM macro, so it is
  // reset to give a defined value on wb_read_data after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_buf <= '0;
    end else if (busy && dmem_ack && mem_read) begin
      read_buf[beat] <= dmem_rdata;
    end
  end

  // Bus outputs decode the state register; the ex/mem register is frozen
  // while busy, so address and data stay stable across wait cycles.
  assign dmem_req   = busy;
  assign dmem_we    = busy & mem_write;
  assign dmem_addr  = busy ? beat_addr : '0;
  assign dmem_wdata = busy ? write_lanes[beat] : '0;
  assign mem_stall  = ((state == IDLE) & acc) | busy;

endmodule

// File: rtl/stage_memory.sv
// Memory stage: drives the beat controller and holds the mem/wb pipeline
// register, replicating scalar load data across all lanes.
module stage_memory
  import core_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           wb_clear,
  input  logic [31:0]    mem_instr,
  input  logic           mem_reg_write,
  input  logic           mem_mem_write,
  input  logic           mem_mem_read,
  input  logic           mem_vector_op,
  input  logic [1:0]     mem_result_src,
  input  logic [127:0]   mem_alu_result,
  input  logic [127:0]   mem_write_data,
  input  logic [31:0]    mem_pc_plus_4,
  input  logic [127:0]   mem_imm_ext,
  input  logic [4:0]     mem_rd,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [31:0]    dmem_addr,
  output logic [31:0]    dmem_wdata,
  input  logic           dmem_ack,
  input  logic [31:0]    dmem_rdata,
  output logic           mem_stall,
  output logic [31:0]    wb_instr,
  output logic           wb_reg_write,
  output logic [1:0]     wb_result_src,
  output logic           wb_vector_op,
  output logic [127:0]   wb_alu_result,
  output logic [127:0]   wb_read_data,
  output logic [31:0]    wb_pc_plus_4,
  output logic [127:0]   wb_imm_ext,
  output logic [4:0]     wb_rd
);

  logic [LANES-1:0][31:0] read_buf;
  logic [127:0]           read_word;
  logic [127:0]           read_sel;

  dmem_beat_ctrl u_beat_ctrl (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_mem_read),
    .mem_write  (mem_mem_write),
    .vector_op  (mem_vector_op),
    .addr_word  (mem_alu_result[31:2]),
    .write_data (mem_write_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .mem_stall  (mem_stall),
    .read_buf   (read_buf)
  );

  assign read_word = mem_vector_op ? read_buf : {LANES{read_buf[0]}};
  assign read_sel  = mem_mem_read ? read_word : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_instr      <= '0;
      wb_reg_write  <= 1'b0;
      wb_result_src <= '0;
      wb_vector_op  <= 1'b0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_pc_plus_4  <= '0;
      wb_imm_ext    <= '0;
      wb_rd         <= '0;
    end else if (wb_clear) begin
      wb_instr      <= '0;
      wb_reg_write  <= 1'b0;
      wb_result_src <= '0;
      wb_vector_op  <= 1'b0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
      wb_pc_plus_4  <= '0;
      wb_imm_ext    <= '0;
      wb_rd         <= '0;
    end else if (mem_stall) begin
      // Bubble: only the fields that can cause architectural effects are killed.
      wb_instr      <= '0;
      wb_reg_write  <= 1'b0;
    end else begin
      wb_instr      <= mem_instr;
      wb_reg_write  <= mem_reg_write;
      wb_result_src <= mem_result_src;
      wb_vector_op  <= mem_vector_op;
      wb_alu_result <= mem_alu_result;
      wb_read_data  <= read_sel;
      wb_pc_plus_4  <= mem_pc_plus_4;
      wb_imm_ext    <= mem_imm_ext;
      wb_rd         <= mem_rd;
    end
  end

endmodule

// File: doc/stage_memory.md
# stage_memory

Memory stage of the five-stage core, directly downstream of the execute stage. It consumes the execute/memory pipeline register (address in `mem_alu_result`, store data in `mem_write_data`, control bits), runs scalar or 128-bit vector loads and stores over a 32-bit data-memory handshake bus, and holds `mem_stall` high while an access is in flight. Results go into the memory/writeback pipeline register.

## Interface
- `LANES`, 4: 32-bit lanes per vector word; beats per vector access.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears FSM and all registered outputs.
- `wb_clear`  in  1  synchronous flush of the mem/wb register (bubble insert).
- `mem_instr`  in  32  debug instruction word, passed through.
- `mem_reg_write`, `mem_mem_write`, `mem_mem_read`, `mem_vector_op`  in  1 each  control from execute.
- `mem_result_src`  in  2  writeback mux select, passed through.
- `mem_alu_result`  in  128  bits [31:0] are the byte address for accesses; whole value passed through.
- `mem_write_data`  in  128  store data; lane i = bits [32i+31:32i].
- `mem_pc_plus_4`  in  32;  `mem_imm_ext`  in  128;  `mem_rd`  in  5  passed through.
- `dmem_req`  out  1  access request, registered state decode.
- `dmem_we`  out  1  1 = write beat.
- `dmem_addr`  out  32  word-aligned beat address.
- `dmem_wdata`  out  32  beat store data.
- `dmem_ack`  in  1  beat done; read data valid the same cycle.
- `dmem_rdata`  in  32  beat read data.
- `mem_stall`  out  1  freezes fetch through execute, including the ex/mem register.
- `wb_instr` 32, `wb_reg_write` 1, `wb_result_src` 2, `wb_vector_op` 1, `wb_alu_result` 128, `wb_read_data` 128, `wb_pc_plus_4` 32, `wb_imm_ext` 128, `wb_rd` 5  out  mem/wb register.

## Operation
- Access pending: `acc = mem_mem_read | mem_mem_write`. Beat count N = `LANES` if `mem_vector_op`, else 1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if `acc`, go to BUSY and clear `beat` to 0. Otherwise stay.
  - BUSY: `dmem_req`=1, `dmem_we`=`mem_mem_write`.
    - `dmem_addr` = ({`mem_alu_result[31:2]`,2'b00} + 4·`beat`) mod 2^32; wraps past 0xFFFFFFFC.
    - `dmem_wdata` = lane `beat` of `mem_write_data`.
    - On `dmem_ack` with a read: capture `dmem_rdata` into lane `beat` of the read buffer.
    - On `dmem_ack` with `beat`=N-1: go to DONE. Otherwise on `dmem_ack`: `beat`+1.
    - Without `dmem_ack`: hold. Address, data and `we` stay stable until acked.
  - DONE: go to IDLE unconditionally.
- Scalar read: buffer lane 0 is replicated into all four lanes of `wb_read_data`.
- Address bits [1:0] are dropped; there is no misalignment trap.
- `mem_stall` = (IDLE & `acc`) | BUSY. It is 0 in DONE, so the ex/mem register advances that cycle.
- mem/wb register, priority order:
  1. `reset`: all outputs 0.
  2. `wb_clear`: all outputs 0.
  3. `mem_stall`: bubble. `wb_reg_write`=0 and `wb_instr`=0; other fields hold.
  4. Otherwise: capture all pass-throughs. `wb_read_data` takes the read buffer; it is 0 for non-read instructions.
- `dmem_ack` outside BUSY is ignored.

## Timing
- Reset values: FSM IDLE, `beat`=0, read buffer 0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, every `wb_*`=0.
  - `mem_stall` is combinational: 0 in IDLE when no access is pending, and it follows `acc` as soon as reset is released.
- Non-memory instruction: 1-cycle latency to wb, no stall.
- Access with zero-wait ack: the stall lasts 1 (IDLE) + N (BUSY) cycles; wb captures at the end of the DONE cycle.
  - Scalar: 3 cycles total. Vector: 6 cycles total.
- Each cycle without `dmem_ack` in BUSY adds one stall cycle.
- `reset` mid-access: `dmem_req` drops asynchronously and the partial read data is discarded. A retry is not this block's responsibility.
- `wb_clear` during BUSY does not abort the bus access; it only bubbles the wb register that cycle.

## Structure
- `core_pkg`:
  - `mem_state_t` enum {IDLE, BUSY, DONE}.
  - `LANES`=4, `WORD_BYTES`=4.
- One sub-module: `dmem_beat_ctrl`, containing the FSM, beat counter, address/data generation, read buffer and `mem_stall`.
- The top level holds the mem/wb register and the read-data replication.

## Test plan
- ALU op, `mem_alu_result`=0x5, `mem_rd`=3, `mem_reg_write`=1 → no stall, `dmem_req` never 1; next cycle `wb_alu_result`=0x5, `wb_rd`=3.
- Scalar load at 0x100, ack every cycle, `dmem_rdata`=0xDEADBEEF → `mem_stall` for 2 cycles; one beat at 0x100; `wb_read_data`={4{0xDEADBEEF}}.
- Vector store at 0x200, `mem_write_data`=0x44444444_33333333_22222222_11111111 → beats at 0x200/204/208/20C carry 0x11111111…0x44444444 with `dmem_we`=1; stall 5 cycles; `wb_reg_write`=0.
- Vector load at 0xFFFFFFF8, ack withheld 2 cycles on beat 1 → addresses FFFFFFF8, FFFFFFFC, 0, 4; address held during the wait; stall 7 cycles; lanes assemble in order.
- `reset` pulsed on beat 2 of a vector load → `dmem_req`=0 and all `wb_*`=0 immediately; after release with no access pending, `mem_stall`=0 in IDLE.
- `wb_clear` on the DONE cycle of a load → wb outputs 0; FSM returns to IDLE.
